// File: rtl/rgb_pwm_fader.sv
// rgb_pwm_fader
//   LED output stage behind the colour sequencer. It accepts a target RGB colour over a
//   valid/ready handshake and drives three PWM pins. Each channel's duty ramps one LSB at
//   a time from the current colour to the target, so colour changes are smooth fades.
//
// Parameters
//   PWM_BITS   : duty and counter width; the PWM period is 2**PWM_BITS clock cycles
//   FADE_DIV   : PWM periods per one-LSB fade step (>= 1)
//   ACTIVE_LOW : 1 inverts the RGB_* pins (LED lit when the pin is low)
//
// Ports
//   clk            : system clock
//   rst            : synchronous active-high reset
//   in_valid       : target colour valid
//   in_ready       : target can be accepted (combinational, idle and not in reset)
//   in_r/in_g/in_b : target duty per channel
//   busy           : registered, high while a fade is in progress
//   RGB_R/G/B      : registered PWM outputs
module rgb_pwm_fader #(
  parameter int unsigned PWM_BITS   = 8,
  parameter int unsigned FADE_DIV   = 4,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [PWM_BITS-1:0] in_r,
  input  logic [PWM_BITS-1:0] in_g,
  input  logic [PWM_BITS-1:0] in_b,
  output logic                busy,
  output logic                RGB_R,
  output logic                RGB_G,
  output logic                RGB_B
);

  localparam int unsigned          DivW    = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam logic [DivW-1:0]      DivLast = DivW'(FADE_DIV - 1);
  localparam logic [PWM_BITS-1:0]  CntMax  = '1;

  typedef enum logic [0:0] {StIdle, StFade} state_e;

  state_e state_q, state_d;

  logic [PWM_BITS-1:0]        pwm_cnt_q, pwm_cnt_d;
  logic [DivW-1:0]            div_cnt_q, div_cnt_d;
  // Channel index 0 = red, 1 = green, 2 = blue.
  logic [2:0][PWM_BITS-1:0]   cur_q, cur_d;
  logic [2:0][PWM_BITS-1:0]   tgt_q, tgt_d;
  logic [2:0][PWM_BITS-1:0]   in_col;
  logic [2:0]                 rgb_q, rgb_d;
  logic                       busy_q;

  logic period_end;
  logic step_tick;
  logic handshake;
  logic fade_step;

  assign in_col     = {in_b, in_g, in_r};
  assign period_end = (pwm_cnt_q == CntMax);
  assign step_tick  = period_end && (div_cnt_q == DivLast);
  assign handshake  = in_valid && in_ready;
  assign fade_step  = (state_q == StFade) && step_tick;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        // A target equal to the current colour is accepted without starting a fade.
        if (handshake && (in_col != cur_q)) begin
          state_d = StFade;
        end
      end
      StFade: begin
        if (fade_step && (cur_d == tgt_q)) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready = (state_q == StIdle) && !rst;
  end

  // ---------------------------------------------------------------------------
  // Datapath next state
  // ---------------------------------------------------------------------------
  always_comb begin
    pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);

    div_cnt_d = div_cnt_q;
    if (handshake) begin
      // Restart step timing so the first step lands FADE_DIV full period ends later.
      div_cnt_d = '0;
    end else if (period_end) begin
      div_cnt_d = (div_cnt_q == DivLast) ? '0 : div_cnt_q + DivW'(1);
    end

    tgt_d = handshake ? in_col : tgt_q;

    // Steps only happen on a period end, so every PWM period uses a single duty.
    cur_d = cur_q;
    if (fade_step) begin
      for (int i = 0; i < 3; i++) begin
        if (cur_q[i] < tgt_q[i]) begin
          cur_d[i] = cur_q[i] + PWM_BITS'(1);
        end else if (cur_q[i] > tgt_q[i]) begin
          cur_d[i] = cur_q[i] - PWM_BITS'(1);
        end
      end
    end

    for (int i = 0; i < 3; i++) begin
      rgb_d[i] = (pwm_cnt_q < cur_q[i]) ^ ACTIVE_LOW;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt_q <= '0;
      div_cnt_q <= '0;
      cur_q     <= '0;
      tgt_q     <= '0;
      busy_q    <= 1'b0;
      rgb_q     <= {3{ACTIVE_LOW}};
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
      div_cnt_q <= div_cnt_d;
      cur_q     <= cur_d;
      tgt_q     <= tgt_d;
      busy_q    <= (state_d == StFade);
      rgb_q     <= rgb_d;
    end
  end

  assign busy  = busy_q;
  assign RGB_R = rgb_q[0];
  assign RGB_G = rgb_q[1];
  assign RGB_B = rgb_q[2];

endmodule
